rv_mem_sys: RTL and testbench

// Memory subsystem on the far side of the multicycle RISC-V core's memory interface.

---
 rtl/rv_mem_sys.sv | 162 ++++++++++++++++
 tb/tb_rv_mem_sys.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_sys.sv
// rtl/rv_mem_sys.sv - instruction ROM, data RAM, output FIFO and cycle counter behind the core memory port

module rv_out_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    ovf
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop;
   logic             push_ok;

   assign out_valid = (count != '0);
   assign full      = (count == CW'(DEPTH));
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   // pop is resolved first, so a full FIFO still takes a push in a draining cycle
   always_comb begin
      pop     = out_valid && out_ready;
      push_ok = push && (!full || pop);
   end

   // pointers, occupancy and the sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (!push_ok && pop) count <= count - 1'b1;
         if (push && full && !pop) ovf <= 1'b1;
      end
   end

   // storage has no reset; only the head pointer decides what is visible
   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem[wr_ptr] <= push_data;
   end
endmodule

module rv_mem_sys #(
   parameter int    DPWIDTH    = 32,
   parameter int    IMEM_WORDS = 256,
   parameter int    DMEM_WORDS = 256,
   parameter int    FIFO_DEPTH = 4,
   parameter string IMEM_INIT  = "imem.hex"
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DPWIDTH-1:0] imem_addr,
   output logic [DPWIDTH-1:0] imem_data,
   input  logic [DPWIDTH-1:0] dmem_addr,
   input  logic [DPWIDTH-1:0] dmem_wdata,
   input  logic               memrw,
   output logic [DPWIDTH-1:0] dmem_rdata,
   output logic               out_valid,
   output logic [DPWIDTH-1:0] out_data,
   input  logic               out_ready,
   output logic               bus_err
);
   localparam int IW = $clog2(IMEM_WORDS);
   localparam int DW = $clog2(DMEM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DPWIDTH-1:0] OUT_ADDR    = DPWIDTH'(32'hFFFF_FF00);
   localparam logic [DPWIDTH-1:0] STATUS_ADDR = DPWIDTH'(32'hFFFF_FF04);
   localparam logic [DPWIDTH-1:0] CYCLE_ADDR  = DPWIDTH'(32'hFFFF_FF08);

   logic [DPWIDTH-1:0] rom [IMEM_WORDS];
   logic [DPWIDTH-1:0] ram [DMEM_WORDS];
   logic [DPWIDTH-1:0] cycle_cnt;
   logic [DPWIDTH-1:0] status;
   logic [CW-1:0]      fifo_count;
   logic               fifo_full;
   logic               fifo_ovf;
   logic               hit_ram;
   logic               hit_out;
   logic               hit_status;
   logic               hit_cycle;
   logic               unmapped;
   logic               unused_addr_bits;

   // byte offsets and high instruction address bits are deliberately ignored (aliasing)
   assign unused_addr_bits = ^{imem_addr[DPWIDTH-1:IW+2], imem_addr[1:0], dmem_addr[1:0]};
   assign imem_data = rom[imem_addr[IW+1:2]];

   // word-granular address decode of the data port
   always_comb begin
      hit_ram    = (dmem_addr[DPWIDTH-1:DW+2] == '0);
      hit_out    = (dmem_addr[DPWIDTH-1:2] == OUT_ADDR[DPWIDTH-1:2]);
      hit_status = (dmem_addr[DPWIDTH-1:2] == STATUS_ADDR[DPWIDTH-1:2]);
      hit_cycle  = (dmem_addr[DPWIDTH-1:2] == CYCLE_ADDR[DPWIDTH-1:2]);
      unmapped   = !(hit_ram || hit_out || hit_status || hit_cycle);
   end

   // status word: count in [15:8], ovf/full/empty flags in [3:1]
   always_comb begin
      status         = '0;
      status[8 +: CW] = fifo_count;
      status[3]      = fifo_ovf;
      status[2]      = fifo_full;
      status[1]      = !out_valid;
   end

   // combinational load path; OUT and unmapped addresses read as zero
   always_comb begin
      dmem_rdata = '0;
      if (hit_ram)         dmem_rdata = ram[dmem_addr[DW+1:2]];
      else if (hit_status) dmem_rdata = status;
      else if (hit_cycle)  dmem_rdata = cycle_cnt;
   end

   // RAM store; a store issued during reset is discarded
   always_ff @(posedge clk) begin
      if (memrw && hit_ram && !rst) ram[dmem_addr[DW+1:2]] <= dmem_wdata;
   end

   // free-running cycle counter, cleared by reset or by any write to it
   always_ff @(posedge clk) begin
      if (rst || (memrw && hit_cycle)) cycle_cnt <= '0;
      else                             cycle_cnt <= cycle_cnt + 1'b1;
   end

   // sticky error for any access that misses the memory map
   always_ff @(posedge clk) begin
      if (rst)           bus_err <= 1'b0;
      else if (unmapped) bus_err <= 1'b1;
   end

   rv_out_fifo #(
      .WIDTH (DPWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (memrw && hit_out),
      .push_data (dmem_wdata),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .ovf       (fifo_ovf)
   );
endmodule

// File: tb/tb_rv_mem_sys.sv
// tb/tb_rv_mem_sys.sv - directed and randomized checks of rv_mem_sys against a queue-based model
`timescale 1ns/1ps
module tb_rv_mem_sys;
   localparam logic [31:0] A_OUT  = 32'hFFFF_FF00;
   localparam logic [31:0] A_STAT = 32'hFFFF_FF04;
   localparam logic [31:0] A_CYC  = 32'hFFFF_FF08;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        memrw;
   logic [31:0] dmem_rdata;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        bus_err;

   int tests = 0;
   int fails = 0;

   logic [31:0] rom_m [256];
   logic [31:0] ram_m [256];
   bit          ram_known [256];
   logic [31:0] q [$];
   bit          ovf_m = 1'b0;
   bit          berr_m = 1'b0;
   logic [31:0] cyc_m = '0;

   always #5 clk = ~clk;

   rv_mem_sys #(
      .DPWIDTH    (32),
      .IMEM_WORDS (256),
      .DMEM_WORDS (256),
      .FIFO_DEPTH (4),
      .IMEM_INIT  ("")
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .memrw      (memrw),
      .dmem_rdata (dmem_rdata),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .bus_err    (bus_err)
   );

   // 0 RAM, 1 OUT, 2 STATUS, 3 CYCLE, 4 unmapped
   function automatic int kind(input logic [31:0] a);
      if (a < 32'd1024) return 0;
      if (a[31:2] == A_OUT[31:2]) return 1;
      if (a[31:2] == A_STAT[31:2]) return 2;
      if (a[31:2] == A_CYC[31:2]) return 3;
      return 4;
   endfunction

   function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
      int k;
      k = kind(a);
      v = '0;
      if (k == 0) begin
         v = ram_m[a[9:2]];
         return ram_known[a[9:2]];
      end
      if (k == 2) begin
         v[15:8] = 8'(q.size());
         v[3] = ovf_m;
         v[2] = (q.size() == 4);
         v[1] = (q.size() == 0);
      end
      if (k == 3) v = cyc_m;
      return 1'b1;
   endfunction

   task automatic model_edge(input bit r, input bit we, input logic [31:0] a,
                             input logic [31:0] wd, input bit rdy);
      int k;
      if (r) begin
         q.delete();
         ovf_m = 1'b0;
         berr_m = 1'b0;
         cyc_m = '0;
         return;
      end
      k = kind(a);
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (we && k == 1) begin
         if (q.size() < 4) q.push_back(wd);
         else ovf_m = 1'b1;
      end
      if (we && k == 0) begin
         ram_m[a[9:2]] = wd;
         ram_known[a[9:2]] = 1'b1;
      end
      if (we && k == 3) cyc_m = '0;
      else cyc_m = cyc_m + 32'd1;
      if (k == 4) berr_m = 1'b1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input bit rdy);
      logic [31:0] ev;
      bit known;
      rst = r;
      memrw = we;
      dmem_addr = a;
      dmem_wdata = wd;
      out_ready = rdy;
      #1;
      known = model_read(a, ev);
      if (known) check("dmem_rdata", dmem_rdata, ev);
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("out_data", out_data, (q.size() != 0) ? q[0] : 32'd0);
      check("bus_err", 32'(bus_err), 32'(berr_m));
      check("imem_data", imem_data, rom_m[imem_addr[9:2]]);
      @(posedge clk);
      model_edge(r, we, a, wd, rdy);
      #1;
   endtask

   task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
      memrw = 1'b0;
      dmem_addr = a;
      #1;
      check(tag, dmem_rdata, exp);
      cyc(1'b0, 1'b0, a, 32'd0, 1'b0);
   endtask

   initial begin
      logic [31:0] a;
      int sel;
      for (int i = 0; i < 256; i++) begin
         rom_m[i] = $urandom;
         ram_known[i] = 1'b0;
      end
      rom_m[0] = 32'h0000_0093;
      for (int i = 0; i < 256; i++) dut.rom[i] = rom_m[i];
      rst = 1'b1; memrw = 1'b0; dmem_addr = '0; dmem_wdata = '0; out_ready = 1'b0; imem_addr = '0;
      @(posedge clk);
      @(posedge clk);
      model_edge(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);

      imem_addr = 32'h0; #1;
      check("rom_word0", imem_data, 32'h0000_0093);
      imem_addr = 32'h400; #1;
      check("rom_alias", imem_data, 32'h0000_0093);

      cyc(1'b0, 1'b1, 32'h14, 32'h1234_5678, 1'b0);
      cyc(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      rd_expect("ram_0x10", 32'h10, 32'hDEAD_BEEF);
      rd_expect("ram_0x13", 32'h13, 32'hDEAD_BEEF);
      rd_expect("ram_0x14", 32'h14, 32'h1234_5678);
      cyc(1'b0, 1'b1, 32'h20, 32'h1111_1111, 1'b0);
      cyc(1'b1, 1'b1, 32'h20, 32'h2222_2222, 1'b0);
      rd_expect("ram_store_in_rst", 32'h20, 32'h1111_1111);

      for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, A_OUT, 32'(i), 1'b0);
      rd_expect("status_full_ovf", A_STAT, 32'h0000_040C);
      for (int i = 1; i <= 4; i++) begin
         check("drain_order", out_data, 32'(i));
         cyc(1'b0, 1'b0, 32'h0, 32'd0, 1'b1);
      end
      rd_expect("status_empty_ovf", A_STAT, 32'h0000_000A);

      cyc(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
      for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, A_OUT, 32'(i * 32'h11), 1'b0);
      cyc(1'b0, 1'b1, A_OUT, 32'h55, 1'b1);
      rd_expect("status_full_pop_push", A_STAT, 32'h0000_0404);
      for (int i = 2; i <= 5; i++) begin
         check("drain_after_pop_push", out_data, 32'(i * 32'h11));
         cyc(1'b0, 1'b0, 32'h0, 32'd0, 1'b1);
      end

      cyc(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
      rd_expect("cycle_10", A_CYC, 32'd10);
      cyc(1'b0, 1'b1, A_CYC, 32'hFFFF_FFFF, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
      rd_expect("cycle_after_clear", A_CYC, 32'd1);

      rd_expect("unmapped_read", 32'h8000_0000, 32'd0);
      check("bus_err_set", 32'(bus_err), 32'd1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, A_OUT, 32'hA0 + 32'(i), 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 32'd0, 1'b1);
      cyc(1'b1, 1'b0, 32'h0, 32'd0, 1'b1);
      check("rst_mid_drain_valid", 32'(out_valid), 32'd0);
      check("rst_mid_drain_data", out_data, 32'd0);
      check("rst_mid_drain_berr", 32'(bus_err), 32'd0);

      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 19);
         if (sel < 10)       a = {22'd0, 4'($urandom_range(0, 15)), 4'd0, 2'($urandom_range(0, 3))};
         else if (sel < 14)  a = A_OUT;
         else if (sel < 16)  a = A_STAT;
         else if (sel < 18)  a = A_CYC;
         else if (sel == 18) a = 32'h0000_0400 + ($urandom & 32'h0FFF_FFFC);
         else                a = {24'd0, 8'($urandom)} << 2;
         imem_addr = $urandom;
         cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), a, $urandom,
             1'($urandom_range(0, 2) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
